axi_lite_regfile: RTL and testbench
===================================

# axi_lite_regfile

Parametrised AXI4-Lite slave register file, the successor to the fixed four-register AXIslave peripheral. It sits behind the interconnect as an S00_AXI-style control port and exposes NUM_REGS software registers to fabric logic. Each register is either read/write, driven by software, or read-only, reflecting a fabric status input. Over the fixed four-register slave it adds byte-strobe writes, independent AW/W acceptance, SLVERR on bad accesses, and per-register access pulses.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus and register width; legal values 32 or 64.
- C_S_AXI_ADDR_WIDTH, 8, byte address width; must be ≥ clog2(NUM_REGS) + clog2(C_S_AXI_DATA_WIDTH/8).
- NUM_REGS, 16, number of registers; legal range 2..256.
- RO_MASK, 0, NUM_REGS-bit mask; bit k=1 makes register k read-only (status).

Ports. Reset is asynchronous, active-low (ARESETN).
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
- reg_out  out  NUM_REGS*C_S_AXI_DATA_WIDTH  flattened register contents; register k occupies slice k
- reg_in  in  NUM_REGS*C_S_AXI_DATA_WIDTH  status values returned for RO registers
- wr_pulse  out  NUM_REGS  one-cycle strobe on each committed write
- rd_pulse  out  NUM_REGS  one-cycle strobe on each accepted read

## Operation
- Decode: ADDR_LSB = clog2(C_S_AXI_DATA_WIDTH/8).
  - idx = addr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]; the low ADDR_LSB bits are ignored.
  - idx ≥ NUM_REGS is out of range.
- Write channel states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - AW and W are accepted independently. S_AXI_AWREADY = 1 in W_IDLE and W_HAVE_DATA; S_AXI_WREADY = 1 in W_IDLE and W_HAVE_ADDR.
  - W_IDLE goes to W_RESP if both handshake on the same edge, W_HAVE_ADDR if only AW, W_HAVE_DATA if only W.
  - W_HAVE_ADDR or W_HAVE_DATA goes to W_RESP on the missing handshake.
  - W_RESP goes to W_IDLE on BVALID && BREADY.
- Commit happens on the edge that enters W_RESP:
  - RW in-range register: each byte with WSTRB=1 is updated; other bytes are unchanged. BRESP = OKAY. wr_pulse[idx] is high for the following cycle.
  - Out-of-range or RO register: no state change, BRESP = SLVERR, no wr_pulse.
- Read channel states: R_IDLE, R_RESP. S_AXI_ARREADY = 1 only in R_IDLE.
  - On the AR handshake edge, RDATA and RRESP are registered and the block enters R_RESP.
  - RW register: returns the register value. RO register: returns reg_in slice, RRESP = OKAY.
  - Out of range: RDATA = 0, RRESP = SLVERR, no rd_pulse.
  - rd_pulse[idx] is high for one cycle after the AR handshake on in-range registers.
  - R_RESP goes to R_IDLE on RVALID && RREADY.
- Read and write channels are fully independent. If the AR handshake coincides with a write commit to the same register, the read returns the pre-write value.
- RO register bits in reg_out are held at 0.

## Timing
- Reset (ARESETN low, asynchronous): all registers, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse and rd_pulse go to 0. AWREADY, WREADY and ARREADY go to 0 while reset is asserted and to 1 on the first edge after deassertion.
- Reset mid-transaction discards any latched AW/W/AR and drops BVALID/RVALID immediately. No partial write takes effect.
- Write latency: BVALID rises one edge after the later of the AW/W handshakes; reg_out updates on that same edge.
- Back-to-back writes with BREADY tied high: one write per 2 cycles. Read, with RREADY high: RVALID one edge after the AR handshake, one read per 2 cycles.
- Stability: BRESP is held while BVALID && !BREADY; RDATA/RRESP are held while RVALID && !RREADY.
- AWREADY, WREADY and ARREADY are low during W_RESP/R_RESP, so no new command is accepted while a response is pending.

## Test plan
- Sequential RW: write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC with WSTRB=0xF, then read back -> each read returns the written value with RRESP=00, and wr_pulse[0..3] each pulse once.
- Byte strobes: write 0xAABBCCDD to reg 5 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5 -> reg 5 reads 0xAA22CC44.
- Channel skew: AWVALID at cycle 0, WVALID delayed to cycle 3 -> BVALID rises at cycle 4 and the write lands. Repeat with W leading AW by 3 cycles -> same result.
- Errors: write to idx = NUM_REGS, and write to an RO register -> BRESP=10 with contents unchanged. Read of the RO register with reg_in slice = 0xDEADBEEF -> RDATA=0xDEADBEEF, RRESP=00. Out-of-range read -> 0 with RRESP=10.
- Backpressure: hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID and the response fields stay stable, and no new AW/AR is accepted until the response handshake completes.
- Reset mid-op: assert ARESETN low after the AW handshake but before W -> after release, reg contents are 0 with no BVALID. A subsequent full write then completes normally.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS RW/RO registers, byte strobes,
// SLVERR on bad accesses, flattened reg_out/reg_in, wr/rd access pulses.
module axi_lite_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0] S_AXI_AWPROT,
  input  logic S_AXI_AWVALID,
  output logic S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic S_AXI_WVALID,
  output logic S_AXI_WREADY,
  output logic [1:0] S_AXI_BRESP,
  output logic S_AXI_BVALID,
  input  logic S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0] S_AXI_ARPROT,
  input  logic S_AXI_ARVALID,
  output logic S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0] S_AXI_RRESP,
  output logic S_AXI_RVALID,
  input  logic S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0] wr_pulse,
  output logic [NUM_REGS-1:0] rd_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic alive;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [IDX_W-1:0] c_idx, r_idx;
  logic [DW-1:0] c_data;
  logic [SW-1:0] c_strb;
  logic [NUM_REGS-1:0] w_hit, r_hit;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] reg_q [NUM_REGS];

  // Readies stay low through reset and rise on the first edge after it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) alive <= 1'b0;
    else alive <= 1'b1;
  end

  assign S_AXI_AWREADY = alive &&
    (w_state == W_IDLE || w_state == W_HAVE_DATA);
  assign S_AXI_WREADY = alive &&
    (w_state == W_IDLE || w_state == W_HAVE_ADDR);
  assign S_AXI_ARREADY = alive && (r_state == R_IDLE);
  assign S_AXI_BVALID = (w_state == W_RESP);
  assign S_AXI_RVALID = (r_state == R_RESP);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs) w_next = W_HAVE_ADDR;
        else if (w_hs) w_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs) w_next = W_RESP;
      W_HAVE_DATA: if (aw_hs) w_next = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_RESP;
      R_RESP: if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // The write commits on the edge entering W_RESP; the half arriving on
  // that edge comes straight from the bus, the other from its latch.
  assign commit = (w_state != W_RESP) && (w_next == W_RESP);
  assign c_idx = aw_hs ?
    S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] : aw_idx_q;
  assign c_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign c_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign r_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  // Empty hit vectors mean out of range (or RO for writes) -> SLVERR.
  always_comb begin
    w_hit = '0;
    r_hit = '0;
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(c_idx) == k && !RO_MASK[k]) w_hit[k] = 1'b1;
      if (32'(r_idx) == k) begin
        r_hit[k] = 1'b1;
        rd_word = RO_MASK[k] ? reg_in[k*DW +: DW] : reg_q[k];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_BRESP <= OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= commit ? w_hit : '0;
      if (commit) S_AXI_BRESP <= (|w_hit) ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= OKAY;
      rd_pulse <= '0;
    end else begin
      rd_pulse <= ar_hs ? r_hit : '0;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_word;
        S_AXI_RRESP <= (|r_hit) ? OKAY : SLVERR;
      end
    end
  end

  // RO entries are never written, so their reg_out slices stay zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_hit[k]) begin
          for (int b = 0; b < SW; b++) begin
            if (c_strb[b]) reg_q[k][b*8 +: 8] <= c_data[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[k*DW +: DW] = reg_q[k];
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
    S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: RW, strobes, skew, errors,
// backpressure and mid-transaction reset.
module tb_axi_lite_regfile;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic bvalid, bready, arvalid, arready, rvalid, rready;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0] wr_pulse, rd_pulse;

  axi_lite_regfile #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR),
    .RO_MASK(RO)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out),
    .reg_in(reg_in),
    .wr_pulse(wr_pulse),
    .rd_pulse(rd_pulse)
  );

  typedef struct {
    logic [1:0] resp;
    logic [NR-1:0] pulse;
  } bexp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0] resp;
    logic [NR-1:0] pulse;
  } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];
  logic [DW-1:0] mem [NR];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
    input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW/8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                    input logic [3:0] s, input int aw_dly, input int w_dly,
                    input bit hold);
    bexp_t e;
    int idx, cyc;
    bit ok, aw_done, w_done, aw_f, w_f;
    idx = int'(addr) / 4;
    ok = (idx < NR) ? !RO[idx] : 1'b0;
    e.resp = ok ? 2'b00 : 2'b10;
    e.pulse = ok ? (NR'(1) << idx) : '0;
    bq.push_back(e);
    if (ok) mem[idx] = merge(mem[idx], d, s);
    bready = !hold;
    aw_done = 0;
    w_done = 0;
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      awvalid = !aw_done && cyc >= aw_dly;
      awaddr = addr;
      wvalid = !w_done && cyc >= w_dly;
      wdata = d;
      wstrb = s;
      #1;
      aw_f = awvalid && awready;
      w_f = wvalid && wready;
      @(posedge clk);
      aw_done |= aw_f;
      w_done |= w_f;
      cyc++;
    end
    chk("wr_hs_cycles", 64'(cyc),
        64'((aw_dly > w_dly ? aw_dly : w_dly) + 1));
    @(negedge clk);
    awvalid = 0;
    wvalid = 0;
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_latency", 64'(cyc), 64'(0));
    e = bq.pop_front();
    chk("bresp", 64'(bresp), 64'(e.resp));
    chk("wr_pulse", 64'(wr_pulse), 64'(e.pulse));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        awvalid = 1;
        #1;
        chk("bp_awready", 64'(awready), 64'(0));
        @(negedge clk);
        chk("bp_bvalid", 64'(bvalid), 64'(1));
        chk("bp_bresp", 64'(bresp), 64'(e.resp));
      end
      awvalid = 0;
      bready = 1;
    end
    @(negedge clk);
    chk("b_done", 64'(bvalid), 64'(0));
    chk("wr_pulse_clr", 64'(wr_pulse), 64'(0));
  endtask

  task automatic rd(input logic [AW-1:0] addr, input bit hold,
                    output logic [DW-1:0] got);
    rexp_t e;
    int idx, cyc;
    bit f;
    idx = int'(addr) / 4;
    if (idx >= NR) begin
      e.data = '0;
      e.resp = 2'b10;
      e.pulse = '0;
    end else begin
      e.data = RO[idx] ? reg_in[idx*DW +: DW] : mem[idx];
      e.resp = 2'b00;
      e.pulse = NR'(1) << idx;
    end
    rq.push_back(e);
    rready = !hold;
    f = 0;
    cyc = 0;
    while (!f && cyc < 50) begin
      @(negedge clk);
      arvalid = 1;
      araddr = addr;
      #1;
      f = arready;
      @(posedge clk);
      cyc++;
    end
    chk("ar_hs", 64'(f), 64'(1));
    @(negedge clk);
    arvalid = 0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("r_latency", 64'(cyc), 64'(0));
    e = rq.pop_front();
    got = rdata;
    chk("rdata", 64'(rdata), 64'(e.data));
    chk("rresp", 64'(rresp), 64'(e.resp));
    chk("rd_pulse", 64'(rd_pulse), 64'(e.pulse));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        arvalid = 1;
        #1;
        chk("bp_arready", 64'(arready), 64'(0));
        @(negedge clk);
        chk("bp_rvalid", 64'(rvalid), 64'(1));
        chk("bp_rdata", 64'(rdata), 64'(e.data));
        chk("bp_rresp", 64'(rresp), 64'(e.resp));
      end
      arvalid = 0;
      rready = 1;
    end
    @(negedge clk);
    chk("r_done", 64'(rvalid), 64'(0));
    chk("rd_pulse_clr", 64'(rd_pulse), 64'(0));
  endtask

  logic [DW-1:0] got;

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    wdata = '0; wstrb = '0;
    bready = 1; rready = 1;
    reg_in = '0;
    reg_in[8*DW +: DW] = 32'hDEADBEEF;
    for (int k = 0; k < NR; k++) mem[k] = '0;

    repeat (2) @(negedge clk);
    chk("rst_awready", 64'(awready), 64'(0));
    chk("rst_wready", 64'(wready), 64'(0));
    chk("rst_arready", 64'(arready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_regs", 64'(|reg_out), 64'(0));
    rst_n = 1;
    @(negedge clk);
    chk("post_awready", 64'(awready), 64'(1));
    chk("post_wready", 64'(wready), 64'(1));
    chk("post_arready", 64'(arready), 64'(1));

    for (int i = 0; i < 4; i++)
      wr(AW'(i*4), DW'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) rd(AW'(i*4), 0, got);
    chk("reg3_out", 64'(reg_out[3*DW +: DW]), 64'(32'h4));

    wr(8'h14, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    wr(8'h14, 32'h11223344, 4'h5, 0, 0, 0);
    rd(8'h14, 0, got);
    chk("reg5_strobe", 64'(got), 64'(32'hAA22CC44));

    wr(8'h18, 32'h600DF00D, 4'hF, 0, 3, 0);
    rd(8'h18, 0, got);
    wr(8'h1C, 32'hCAFE0001, 4'hF, 3, 0, 0);
    rd(8'h1C, 0, got);
    chk("reg7_skew", 64'(got), 64'(32'hCAFE0001));

    wr(8'h40, 32'h12345678, 4'hF, 0, 0, 0);
    wr(8'h20, 32'h12345678, 4'hF, 1, 0, 0);
    chk("ro_regout", 64'(reg_out[8*DW +: DW]), 64'(0));
    rd(8'h20, 0, got);
    chk("ro_read", 64'(got), 64'(32'hDEADBEEF));
    rd(8'h40, 0, got);
    rd(8'h00, 0, got);
    rd(8'h03, 0, got);

    wr(8'h24, 32'h0BADCAFE, 4'hF, 0, 0, 1);
    rd(8'h24, 1, got);
    rd(8'h44, 1, got);

    @(negedge clk);
    awvalid = 1;
    awaddr = 8'h28;
    #1;
    chk("mid_awready", 64'(awready), 64'(1));
    @(negedge clk);
    awvalid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_awready", 64'(awready), 64'(0));
    chk("mid_rst_regs", 64'(|reg_out), 64'(0));
    for (int k = 0; k < NR; k++) mem[k] = '0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_bvalid", 64'(bvalid), 64'(0));
    end
    chk("mid_regs_zero", 64'(|reg_out), 64'(0));
    wr(8'h28, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
    rd(8'h28, 0, got);
    rd(8'h00, 0, got);

    for (int k = 0; k < NR; k++)
      chk("final_regout", 64'(reg_out[k*DW +: DW]),
          64'(RO[k] ? '0 : mem[k]));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
